// File: rtl/tile_sprite_drawer.sv
// Streams one TILE_W x TILE_H sprite from an external image ROM to the VGA plot port.
// Optional macro TRANSPARENCY_EN: pixels whose ROM word equals TRANSPARENT are not plotted.
module tile_sprite_drawer #(
    parameter int unsigned   TILE_W      = 20,
    parameter int unsigned   TILE_H      = 20,
    parameter int unsigned   SPRITE_CNT  = 4,
    parameter int unsigned   ROM_LATENCY = 1,
    parameter int unsigned   COLOUR_W    = 9,
    parameter int unsigned   SCREEN_W    = 160,
    parameter int unsigned   SCREEN_H    = 120,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF,
    localparam int unsigned  SEL_W       = (SPRITE_CNT > 1) ? $clog2(SPRITE_CNT) : 1,
    localparam int unsigned  ADDR_W      = $clog2(SPRITE_CNT * TILE_W * TILE_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          grid_x,
    input  logic [3:0]          grid_y,
    input  logic [SEL_W-1:0]    sprite_sel,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic                busy,
    output logic                done,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    localparam int unsigned TILE_N = TILE_W * TILE_H;
    localparam int unsigned COL_W  = $clog2(TILE_W);
    localparam int unsigned ROW_W  = $clog2(TILE_H);
    localparam int unsigned PX_W   = 12;
    localparam int unsigned PY_W   = 11;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [3:0]        gx_q, gy_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] base;
    int unsigned       sel_idx;

    logic              accept;
    logic              issue_valid;
    logic              last_issue;
    logic              pipe_busy;

    logic              al_valid;
    logic [COL_W-1:0]  al_col;
    logic [ROW_W-1:0]  al_row;

    logic [PX_W-1:0]   px;
    logic [PY_W-1:0]   py;
    logic              in_screen;
    logic              opaque;

    assign accept      = (state_q == StIdle) && start;
    assign issue_valid = (state_q == StRun);
    assign last_issue  = issue_valid && (col_q == COL_W'(TILE_W - 1))
                                     && (row_q == ROW_W'(TILE_H - 1));

    // Out-of-range sprite indices fall back to sprite 0.
    always_comb begin
        sel_idx = 0;
        if (32'(sprite_sel) < SPRITE_CNT) begin
            sel_idx = 32'(sprite_sel);
        end
        base = ADDR_W'(sel_idx * TILE_N);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start)      state_d = StRun;
            StRun:   if (last_issue) state_d = StDrain;
            StDrain: if (!pipe_busy) state_d = StDone;
            StDone:                  state_d = StIdle;
            default:                 state_d = StIdle;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StRun, StDrain: busy = 1'b1;
            StDone:         done = 1'b1;
            default:        ;
        endcase
    end

    // Raster address generator: column fastest, address contiguous within a sprite.
    always_ff @(posedge clk) begin
        if (reset) begin
            gx_q   <= '0;
            gy_q   <= '0;
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (accept) begin
            gx_q   <= grid_x;
            gy_q   <= grid_y;
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= base;
        end else if (issue_valid && !last_issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (col_q == COL_W'(TILE_W - 1)) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    assign rom_addr = addr_q;

    // rom_q is captured by the output register ROM_LATENCY edges after the address is
    // presented, so the tag only needs ROM_LATENCY-1 stages before that register.
    if (ROM_LATENCY > 1) begin : g_pipe
        localparam int unsigned D = ROM_LATENCY - 1;

        logic [D-1:0]     v_q;
        logic [COL_W-1:0] c_q [D];
        logic [ROW_W-1:0] r_q [D];

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= '0;
            end else begin
                v_q[0] <= issue_valid;
                for (int i = 1; i < int'(D); i++) begin
                    v_q[i] <= v_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            c_q[0] <= col_q;
            r_q[0] <= row_q;
            for (int i = 1; i < int'(D); i++) begin
                c_q[i] <= c_q[i-1];
                r_q[i] <= r_q[i-1];
            end
        end

        assign al_valid  = v_q[D-1];
        assign al_col    = c_q[D-1];
        assign al_row    = r_q[D-1];
        assign pipe_busy = |v_q;
    end else begin : g_nopipe
        assign al_valid  = issue_valid;
        assign al_col    = col_q;
        assign al_row    = row_q;
        assign pipe_busy = 1'b0;
    end

    // Screen coordinates carry 4 spare bits so far-off cells clip instead of wrapping.
    assign px = PX_W'(gx_q) * PX_W'(TILE_W) + PX_W'(al_col);
    assign py = PY_W'(gy_q) * PY_W'(TILE_H) + PY_W'(al_row);
    assign in_screen = (px < PX_W'(SCREEN_W)) && (py < PY_W'(SCREEN_H));

`ifdef TRANSPARENCY_EN
    assign opaque = (rom_q != TRANSPARENT);
`else
    logic unused_key;
    assign unused_key = ^TRANSPARENT;
    assign opaque     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else begin
            plot <= al_valid && in_screen && opaque;
            if (al_valid) begin
                x      <= px[7:0];
                y      <= py[6:0];
                colour <= rom_q;
            end
        end
    end

endmodule

// File: tb/tb_tile_sprite_drawer.sv
// Randomised bench for tile_sprite_drawer: expected plot stream and handshake timing are
// derived per draw from tile geometry; the ROM answers combinationally (ROM_LATENCY = 1).
module tb_tile_sprite_drawer;

    localparam int W  = 20;
    localparam int H  = 20;
    localparam int N  = W * H;
    localparam int L  = 1;
    localparam int SW = 160;
    localparam int SH = 120;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  grid_x;
    logic [3:0]  grid_y;
    logic [1:0]  sprite_sel;
    logic [10:0] rom_addr;
    logic [8:0]  rom_q;
    logic        busy;
    logic        done;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  colour;
    logic        plot;

    logic [8:0]  mem [1600];
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    assign rom_q = mem[rom_addr];

    tile_sprite_drawer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .grid_x     (grid_x),
        .grid_y     (grid_y),
        .sprite_sel (sprite_sel),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .busy       (busy),
        .done       (done),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One draw from start to idle; optional extra start pulse and mid-draw reset.
    task automatic run_draw(input int gx, input int gy, input int sel,
                            input int repulse_at, input int abort_at);
        logic [63:0] expq[$];
        logic [63:0] obs;
        int  base;
        int  idx = 0;
        int  nplot = 0;
        int  first_busy = -1;
        int  last_busy = -1;
        int  busy_cnt = 0;
        int  done_cnt = 0;
        int  done_cyc = -1;
        bit  plot_err = 1'b0;
        bit  aborted = 1'b0;

        base = sel * N;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int  px;
                int  py;
                int  a;
                bit  keep;
                logic [15:0] cy;
                logic [7:0]  xx;
                logic [7:0]  yy;
                px   = gx * W + c;
                py   = gy * H + r;
                a    = base + r * W + c;
                keep = (px < SW) && (py < SH);
`ifdef TRANSPARENCY_EN
                if (mem[a] == 9'h1FF) keep = 1'b0;
`endif
                if (keep) begin
                    cy = 16'(1 + L + r * W + c);
                    xx = 8'(px);
                    yy = 8'(py);
                    expq.push_back({23'b0, cy, xx, yy, mem[a]});
                end
            end
        end

        grid_x     = 4'(gx);
        grid_y     = 4'(gy);
        sprite_sel = 2'(sel);
        start      = 1'b1;
        @(posedge clk);

        for (int k = 1; k <= N + L + 3; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (abort_at != 0 && k == abort_at + 1) begin
                check_eq("reset_mid_draw", 64'({busy, plot, done, rom_addr}), 64'(0));
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (busy) begin
                if (first_busy < 0) first_busy = k;
                last_busy = k;
                busy_cnt++;
            end
            if (done) begin
                if (done_cyc < 0) done_cyc = k;
                done_cnt++;
            end
            if (plot) begin
                obs = {23'b0, 16'(k), x, 1'b0, y, colour};
                if (!plot_err && idx < expq.size()) begin
                    check_eq("plot", obs, expq[idx]);
                    plot_err = (obs !== expq[idx]);
                end
                idx++;
                nplot++;
            end
            if (k == 1) check_eq("addr_first", 64'(rom_addr), 64'(base));
            if (k == N) check_eq("addr_last", 64'(rom_addr), 64'(base + N - 1));
            if (repulse_at != 0 && k == repulse_at) start = 1'b1;
            if (repulse_at != 0 && k == repulse_at + 1) start = 1'b0;
            if (abort_at != 0 && k == abort_at) reset = 1'b1;
        end

        if (!aborted) begin
            check_eq("plot_count", 64'(nplot), 64'(expq.size()));
            check_eq("busy_first", 64'(first_busy), 64'(1));
            check_eq("busy_last", 64'(last_busy), 64'(N + L));
            check_eq("busy_count", 64'(busy_cnt), 64'(N + L));
            check_eq("done_count", 64'(done_cnt), 64'(1));
            check_eq("done_cycle", 64'(done_cyc), 64'(N + L + 1));
        end
    endtask

    initial begin
        for (int a = 0; a < 1600; a++) mem[a] = 9'(a);
        reset      = 1'b1;
        start      = 1'b0;
        grid_x     = '0;
        grid_y     = '0;
        sprite_sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_state", 64'({busy, done, plot, rom_addr, x, y, colour}), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        run_draw(0, 0, 0, 0, 0);
        run_draw(7, 5, 2, 0, 0);
        run_draw(8, 0, 1, 0, 0);
        run_draw(7, 6, 3, 0, 0);
        run_draw(3, 2, 0, 100, 0);
        run_draw(2, 1, 1, 0, 200);
        repeat (2) @(negedge clk);
        run_draw(2, 1, 1, 0, 0);

        repeat (10) mem[400 + $urandom_range(0, 399)] = 9'h1FF;
        run_draw(1, 1, 1, 0, 0);

        repeat (4) begin
            run_draw(int'($urandom_range(0, 9)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 3)), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
